// File: rtl/note_sequencer.sv
// Plays a stored {sound code, duration} table into the synthesizer request/read handshake.
// Latency: response (data_rd + sound_code) one cycle after a data_rq rising edge; start->PLAY in 3 cycles.
// Backpressure: none; every request edge is answered, with code 0 whenever no note is playing.
module note_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DUR_W  = 16
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_code,
   input  logic [DUR_W-1:0]  wr_dur,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              data_rq,
   output logic [3:0]        sound_code,
   output logic              data_rd,
   output logic              busy,
   output logic [ADDR_W-1:0] note_idx,
   output logic              done
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_ADVANCE
   } state_t;

   // Note table: code in the upper nibble, duration below it.
   logic [DUR_W+3:0]  r_mem [DEPTH];
   logic [DUR_W+3:0]  r_rd_dat;

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [3:0]        r_code;
   logic [DUR_W-1:0]  r_dur_cnt;
   logic              r_rq_q;
   logic [3:0]        r_sound_code;
   logic              r_data_rd;
   logic              r_busy;
   logic              r_done;

   logic              w_rq_edge;
   logic [3:0]        w_rd_code;
   logic [DUR_W-1:0]  w_rd_dur;
   logic              w_seq_end;

   assign w_rq_edge = data_rq & ~r_rq_q;
   assign w_rd_code = r_rd_dat[DUR_W+3:DUR_W];
   assign w_rd_dur  = r_rd_dat[DUR_W-1:0];
   // Decided when the current entry expires; ADVANCE then follows r_done so the
   // done pulse and the IDLE transition always agree.
   assign w_seq_end = (r_idx == last_addr) && !loop;

   assign sound_code = r_sound_code;
   assign data_rd    = r_data_rd;
   assign busy       = r_busy;
   assign note_idx   = r_idx;
   assign done       = r_done;

   // Table storage: synchronous write, registered read of the current index (contents not reset).
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         r_mem[wr_addr] <= {wr_code, wr_dur};
      end
      r_rd_dat <= r_mem[r_idx];
   end

   // Request handshake and playback state machine with registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_code       <= '0;
         r_dur_cnt    <= '0;
         r_rq_q       <= 1'b0;
         r_sound_code <= '0;
         r_data_rd    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_rq_q    <= data_rq;
         r_data_rd <= w_rq_edge;
         r_done    <= 1'b0;
         // Only PLAY serves a real note; every other state answers with silence.
         if (w_rq_edge) begin
            r_sound_code <= (r_state == S_PLAY) ? r_code : 4'd0;
         end

         if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state <= S_FETCH;
                     r_idx   <= '0;
                     r_busy  <= 1'b1;
                  end
               end
               S_FETCH: begin
                  r_state <= S_LOAD;
               end
               S_LOAD: begin
                  r_code    <= w_rd_code;
                  r_dur_cnt <= w_rd_dur;
                  if (w_rd_dur == '0) begin
                     r_state <= S_ADVANCE;
                     r_done  <= w_seq_end;
                  end else begin
                     r_state <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (w_rq_edge) begin
                     r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                     if (r_dur_cnt == DUR_W'(1)) begin
                        r_state <= S_ADVANCE;
                        r_done  <= w_seq_end;
                     end
                  end
               end
               S_ADVANCE: begin
                  if (r_done) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_idx == last_addr) begin
                     r_idx   <= '0;
                     r_state <= S_FETCH;
                  end else begin
                     r_idx   <= r_idx + ADDR_W'(1);
                     r_state <= S_FETCH;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        wr_en    = 1'b0;
   logic [3:0]  wr_addr  = '0;
   logic [3:0]  wr_code  = '0;
   logic [15:0] wr_dur   = '0;
   logic        start    = 1'b0;
   logic        stop     = 1'b0;
   logic        loop     = 1'b0;
   logic [3:0]  last_addr = '0;
   logic        data_rq  = 1'b0;
   logic [3:0]  sound_code;
   logic        data_rd;
   logic        busy;
   logic [3:0]  note_idx;
   logic        done;

   int n_err  = 0;
   int n_chk  = 0;
   int n_done = 0;
   int done_base;

   note_sequencer #(.ADDR_W(4), .DUR_W(16)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_code   (wr_code),
      .wr_dur    (wr_dur),
      .start     (start),
      .stop      (stop),
      .loop      (loop),
      .last_addr (last_addr),
      .data_rq   (data_rq),
      .sound_code(sound_code),
      .data_rd   (data_rd),
      .busy      (busy),
      .note_idx  (note_idx),
      .done      (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Count done pulses mid-cycle, away from the active edge.
   always @(negedge CLOCK_50) begin
      if (done) n_done++;
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] c, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dur = d;
      tick();
      wr_en = 1'b0;
   endtask

   // One request: rising edge, check the response the next cycle, check the strobe
   // is a single cycle, then idle for gap cycles.
   task automatic req(input string tag, input logic [3:0] exp_code,
                      input logic [3:0] exp_idx, input int gap);
      data_rq = 1'b1;
      tick();
      chk({tag, ".rd"},   32'(data_rd), 32'd1);
      chk({tag, ".code"}, 32'(sound_code), 32'(exp_code));
      chk({tag, ".idx"},  32'(note_idx), 32'(exp_idx));
      data_rq = 1'b0;
      tick();
      chk({tag, ".rd_off"}, 32'(data_rd), 32'd0);
      repeat (gap) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // Reset values
      tick(); tick();
      reset = 1'b0;
      chk("rst.code", 32'(sound_code), 32'd0);
      chk("rst.rd",   32'(data_rd), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.idx",  32'(note_idx), 32'd0);
      chk("rst.done", 32'(done), 32'd0);

      // Idle requests answered with silence, every 4 cycles
      for (int i = 0; i < 3; i++) begin
         req("idle", 4'd0, 4'd0, 2);
         chk("idle.busy", 32'(busy), 32'd0);
      end

      // Single pass: 3,3,7,7,7 then done
      wr(4'd0, 4'd3, 16'd2);
      wr(4'd1, 4'd7, 16'd3);
      last_addr = 4'd1;
      loop = 1'b0;
      done_base = n_done;
      pulse_start();
      chk("once.busy_fetch", 32'(busy), 32'd1);
      tick(); tick();
      req("once0", 4'd3, 4'd0, 6);
      req("once1", 4'd3, 4'd0, 6);
      req("once2", 4'd7, 4'd1, 6);
      req("once3", 4'd7, 4'd1, 6);
      req("once4", 4'd7, 4'd1, 6);
      chk("once.done_cnt", 32'(n_done - done_base), 32'd1);
      chk("once.busy_end", 32'(busy), 32'd0);
      req("once.after", 4'd0, 4'd1, 6);

      // Looping: 3,3,7,7,7,3,3,7,7,7,3,3 with index wrap, no done
      loop = 1'b1;
      done_base = n_done;
      pulse_start();
      tick(); tick();
      req("loop0",  4'd3, 4'd0, 6);
      req("loop1",  4'd3, 4'd0, 6);
      req("loop2",  4'd7, 4'd1, 6);
      req("loop3",  4'd7, 4'd1, 6);
      req("loop4",  4'd7, 4'd1, 6);
      req("loop5",  4'd3, 4'd0, 6);
      req("loop6",  4'd3, 4'd0, 6);
      req("loop7",  4'd7, 4'd1, 6);
      req("loop8",  4'd7, 4'd1, 6);
      req("loop9",  4'd7, 4'd1, 6);
      req("loop10", 4'd3, 4'd0, 6);
      req("loop11", 4'd3, 4'd0, 6);
      chk("loop.busy", 32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("loop.stop_busy", 32'(busy), 32'd0);
      chk("loop.no_done", 32'(n_done - done_base), 32'd0);

      // Zero-duration entry skipped; gap request gets silence
      wr(4'd0, 4'd5, 16'd1);
      wr(4'd1, 4'd9, 16'd0);
      wr(4'd2, 4'd6, 16'd1);
      last_addr = 4'd2;
      loop = 1'b0;
      done_base = n_done;
      pulse_start();
      tick(); tick();
      req("skip0",   4'd5, 4'd0, 1);
      req("skip.gap", 4'd0, 4'd1, 6);
      req("skip2",   4'd6, 4'd2, 2);
      chk("skip.done_cnt", 32'(n_done - done_base), 32'd1);
      chk("skip.busy_end", 32'(busy), 32'd0);

      // Stop and start together mid-note
      wr(4'd0, 4'd4, 16'd5);
      last_addr = 4'd0;
      done_base = n_done;
      pulse_start();
      tick(); tick();
      req("stop.note", 4'd4, 4'd0, 2);
      stop = 1'b1;
      start = 1'b1;
      tick();
      stop = 1'b0;
      start = 1'b0;
      chk("stop.busy", 32'(busy), 32'd0);
      tick();
      chk("stop.busy_hold", 32'(busy), 32'd0);
      req("stop.after", 4'd0, 4'd0, 2);
      chk("stop.no_done", 32'(n_done - done_base), 32'd0);

      // Reset during PLAY with a request edge pending
      wr(4'd0, 4'd4, 16'd1);
      wr(4'd1, 4'd8, 16'd5);
      last_addr = 4'd1;
      pulse_start();
      tick(); tick();
      req("rp0", 4'd4, 4'd0, 6);
      req("rp1", 4'd8, 4'd1, 2);
      data_rq = 1'b1;
      reset = 1'b1;
      tick();
      chk("rp.rd",   32'(data_rd), 32'd0);
      chk("rp.code", 32'(sound_code), 32'd0);
      chk("rp.idx",  32'(note_idx), 32'd0);
      chk("rp.busy", 32'(busy), 32'd0);
      chk("rp.done", 32'(done), 32'd0);
      reset = 1'b0;
      data_rq = 1'b0;
      tick();
      chk("rp.idle_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
